// File: rtl/ibex_wb_hold_stage.sv
// Single-entry writeback hold stage: captures the EX result, waits for the LSU on memory ops,
// then issues one register-file write and one retire pulse. Optional macro: IBEX_WB_RETIRE_CNT_EN.
module ibex_wb_hold_stage #(
  parameter int unsigned RegAddrW = 5,
  parameter int unsigned PerfCntW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_wb_i,
  input  logic [1:0]          instr_type_wb_i,
  input  logic [RegAddrW-1:0] rf_waddr_i,
  input  logic                rf_we_i,
  input  logic [31:0]         rf_wdata_ex_i,
  input  logic                lsu_resp_valid_i,
  input  logic [31:0]         lsu_rdata_i,
  input  logic                lsu_err_i,
  output logic                ready_wb_o,
  output logic                rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o,
  output logic [31:0]         rf_wdata_o,
  output logic [31:0]         rf_wdata_fwd_o,
  output logic [RegAddrW-1:0] rf_waddr_fwd_o,
  output logic                rf_fwd_valid_o,
  output logic                outstanding_mem_o,
  output logic                instr_done_wb_o,
  output logic                lsu_err_wb_o,
  output logic [PerfCntW-1:0] perf_retired_o
);

  localparam logic [1:0] TypeLoad  = 2'd1;
  localparam logic [1:0] TypeStore = 2'd2;

  logic                valid_q, valid_d;
  logic [1:0]          type_q, type_d;
  logic [RegAddrW-1:0] waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;

  logic is_load, is_store, is_mem, wb_done, accept;

  always_comb begin
    is_load  = (type_q == TypeLoad);
    is_store = (type_q == TypeStore);
    is_mem   = is_load | is_store;
    // ALU entries finish in the cycle they occupy WB; memory entries wait for the response.
    wb_done  = valid_q & (is_mem ? lsu_resp_valid_i : 1'b1);
    // Held low during reset so every output reads 0 while rst_i is asserted.
    ready_wb_o = ~rst_i & (~valid_q | wb_done);
    accept     = en_wb_i & ready_wb_o;
  end

  always_comb begin
    valid_d = valid_q;
    type_d  = type_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (accept) begin
      valid_d = 1'b1;
      type_d  = instr_type_wb_i;
      waddr_d = rf_waddr_i;
      wdata_d = rf_wdata_ex_i;
      we_d    = rf_we_i;
    end else if (wb_done) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      type_q  <= 2'd0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      type_q  <= type_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_wdata_o = '0;
    if (valid_q) begin
      if (is_load) begin
        rf_we_o    = lsu_resp_valid_i & we_q & ~lsu_err_i;
        rf_wdata_o = lsu_rdata_i;
      end else if (!is_store) begin
        rf_we_o    = we_q;
        rf_wdata_o = wdata_q;
      end
    end
    rf_waddr_o        = valid_q ? waddr_q : '0;
    instr_done_wb_o   = valid_q & wb_done;
    lsu_err_wb_o      = instr_done_wb_o & is_mem & lsu_err_i;
    outstanding_mem_o = valid_q & is_mem;
    // Only ALU results are forwarded; load data comes straight from the LSU.
    rf_fwd_valid_o    = valid_q & ~is_mem & we_q;
    rf_wdata_fwd_o    = rf_fwd_valid_o ? wdata_q : '0;
    rf_waddr_fwd_o    = rf_fwd_valid_o ? waddr_q : '0;
  end

`ifdef IBEX_WB_RETIRE_CNT_EN
  logic [PerfCntW-1:0] retired_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (instr_done_wb_o) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign perf_retired_o = retired_q;
`else
  assign perf_retired_o = '0;
`endif

endmodule

// File: tb/tb_ibex_wb_hold_stage.sv
// Scoreboard bench for ibex_wb_hold_stage: expected writebacks are queued when instructions are
// driven and compared when the stage retires them.
module tb_ibex_wb_hold_stage;

  localparam int PW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_wb_i;
  logic [1:0]    instr_type_wb_i;
  logic [4:0]    rf_waddr_i;
  logic          rf_we_i;
  logic [31:0]   rf_wdata_ex_i;
  logic          lsu_resp_valid_i;
  logic [31:0]   lsu_rdata_i;
  logic          lsu_err_i;
  logic          ready_wb_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic [31:0]   rf_wdata_fwd_o;
  logic [4:0]    rf_waddr_fwd_o;
  logic          rf_fwd_valid_o;
  logic          outstanding_mem_o;
  logic          instr_done_wb_o;
  logic          lsu_err_wb_o;
  logic [PW-1:0] perf_retired_o;

  ibex_wb_hold_stage #(
    .RegAddrW(5),
    .PerfCntW(PW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .en_wb_i          (en_wb_i),
    .instr_type_wb_i  (instr_type_wb_i),
    .rf_waddr_i       (rf_waddr_i),
    .rf_we_i          (rf_we_i),
    .rf_wdata_ex_i    (rf_wdata_ex_i),
    .lsu_resp_valid_i (lsu_resp_valid_i),
    .lsu_rdata_i      (lsu_rdata_i),
    .lsu_err_i        (lsu_err_i),
    .ready_wb_o       (ready_wb_o),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .rf_wdata_fwd_o   (rf_wdata_fwd_o),
    .rf_waddr_fwd_o   (rf_waddr_fwd_o),
    .rf_fwd_valid_o   (rf_fwd_valid_o),
    .outstanding_mem_o(outstanding_mem_o),
    .instr_done_wb_o  (instr_done_wb_o),
    .lsu_err_wb_o     (lsu_err_wb_o),
    .perf_retired_o   (perf_retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks_n = 0;
  int   errs_n   = 0;
  int   cnt_model = 0;

  logic outs_or;
  assign outs_or = rf_we_o | (|rf_waddr_o) | (|rf_wdata_o) | (|rf_wdata_fwd_o) |
                   (|rf_waddr_fwd_o) | rf_fwd_valid_o | outstanding_mem_o |
                   instr_done_wb_o | lsu_err_wb_o;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_n++;
    if (act !== exp) begin
      errs_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_perf();
`ifdef IBEX_WB_RETIRE_CNT_EN
    return 64'(cnt_model % (1 << PW));
`else
    return 64'd0;
`endif
  endfunction

  // Retire monitor: every instr_done pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && instr_done_wb_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ret_we", 64'(rf_we_o), 64'(e.we));
        check("ret_addr", 64'(rf_waddr_o), 64'(e.addr));
        if (e.we) check("ret_data", 64'(rf_wdata_o), 64'(e.data));
        check("ret_err", 64'(lsu_err_wb_o), 64'(e.err));
      end
      check("perf_cnt", 64'(perf_retired_o), exp_perf());
      cnt_model++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    en_wb_i          = 1'b0;
    instr_type_wb_i  = 2'd0;
    rf_waddr_i       = '0;
    rf_we_i          = 1'b0;
    rf_wdata_ex_i    = '0;
    lsu_resp_valid_i = 1'b0;
    lsu_rdata_i      = '0;
    lsu_err_i        = 1'b0;
  endtask

  task automatic drive_instr(input logic [1:0] typ, input logic [4:0] addr, input logic we,
                             input logic [31:0] data);
    en_wb_i         = 1'b1;
    instr_type_wb_i = typ;
    rf_waddr_i      = addr;
    rf_we_i         = we;
    rf_wdata_ex_i   = data;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic err);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    #3;
    check("rst_ready", 64'(ready_wb_o), 64'd0);
    check("rst_outs", 64'(outs_or), 64'd0);
    check("rst_perf", 64'(perf_retired_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", 64'(ready_wb_o), 64'd1);
    check("post_rst_outs", 64'(outs_or), 64'd0);
    tick();

    // Back-to-back ALU stream
    for (int i = 0; i < 3; i++) begin
      drive_instr(2'd0, 5'(5 + i), 1'b1, 32'(8'h11 * (i + 1)));
      push_exp(1'b1, 5'(5 + i), 32'(8'h11 * (i + 1)), 1'b0);
      @(negedge clk_i);
      check("alu_ready", 64'(ready_wb_o), 64'd1);
      tick();
    end
    idle_inputs();
    @(negedge clk_i);
    check("fwd_valid", 64'(rf_fwd_valid_o), 64'd1);
    check("fwd_addr", 64'(rf_waddr_fwd_o), 64'd7);
    check("fwd_data", 64'(rf_wdata_fwd_o), 64'h33);
    tick();
    @(negedge clk_i);
    check("empty_outs", 64'(outs_or), 64'd0);
    check("empty_ready", 64'(ready_wb_o), 64'd1);
    tick();

    // Load with two wait cycles, an illegal accept while stalled, then ALU on the response cycle
    drive_instr(2'd1, 5'd10, 1'b1, 32'h0BAD_F00D);
    push_exp(1'b1, 5'd10, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("ld_wait_ready", 64'(ready_wb_o), 64'd0);
    check("ld_wait_outst", 64'(outstanding_mem_o), 64'd1);
    check("ld_wait_we", 64'(rf_we_o), 64'd0);
    check("ld_wait_fwd", 64'(rf_fwd_valid_o), 64'd0);
    tick();
    drive_instr(2'd0, 5'd1, 1'b1, 32'h0000_0BAD);
    @(negedge clk_i);
    check("ld_wait2_ready", 64'(ready_wb_o), 64'd0);
    check("ld_wait2_outst", 64'(outstanding_mem_o), 64'd1);
    tick();
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'hDEAD_BEEF;
    drive_instr(2'd0, 5'd8, 1'b1, 32'h88);
    push_exp(1'b1, 5'd8, 32'h88, 1'b0);
    @(negedge clk_i);
    check("ld_resp_ready", 64'(ready_wb_o), 64'd1);
    tick();
    idle_inputs();
    tick();

    // Load with bus error
    drive_instr(2'd1, 5'd11, 1'b1, 32'h0);
    push_exp(1'b0, 5'd11, 32'h0, 1'b1);
    tick();
    idle_inputs();
    lsu_resp_valid_i = 1'b1;
    lsu_err_i        = 1'b1;
    lsu_rdata_i      = 32'h1234;
    @(negedge clk_i);
    check("lderr_done", 64'(instr_done_wb_o), 64'd1);
    tick();

    // Stray response while empty, then a store
    idle_inputs();
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'hFFFF;
    @(negedge clk_i);
    check("stray_outs", 64'(outs_or), 64'd0);
    check("stray_ready", 64'(ready_wb_o), 64'd1);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("stray_after_outst", 64'(outstanding_mem_o), 64'd0);
    tick();
    drive_instr(2'd2, 5'd3, 1'b0, 32'h55);
    push_exp(1'b0, 5'd3, 32'h0, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("st_outst", 64'(outstanding_mem_o), 64'd1);
    check("st_fwd", 64'(rf_fwd_valid_o), 64'd0);
    tick();
    lsu_resp_valid_i = 1'b1;
    tick();
    idle_inputs();

    // Write to x0 is still strobed; type 3 behaves as ALU
    drive_instr(2'd0, 5'd0, 1'b1, 32'h99);
    push_exp(1'b1, 5'd0, 32'h99, 1'b0);
    tick();
    drive_instr(2'd3, 5'd9, 1'b1, 32'h77);
    push_exp(1'b1, 5'd9, 32'h77, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a pending load
    drive_instr(2'd1, 5'd12, 1'b1, 32'h0);
    push_exp(1'b1, 5'd12, 32'hCAFE, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk_i);
    check("rstmem_outst", 64'(outstanding_mem_o), 64'd1);
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    #1;
    check("rstmem_outs", 64'(outs_or), 64'd0);
    check("rstmem_ready", 64'(ready_wb_o), 64'd0);
    check("rstmem_perf", 64'(perf_retired_o), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'hCAFE;
    @(negedge clk_i);
    check("rstmem_resp_we", 64'(rf_we_o), 64'd0);
    check("rstmem_resp_done", 64'(instr_done_wb_o), 64'd0);
    tick();
    idle_inputs();

    // 17 retires: a 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      drive_instr(2'd0, 5'(i), 1'b1, 32'(i + 100));
      push_exp(1'b1, 5'(i), 32'(i + 100), 1'b0);
      tick();
    end
    idle_inputs();
    tick();
    @(negedge clk_i);
    check("perf_final", 64'(perf_retired_o), exp_perf());
    check("retire_total", 64'(cnt_model), 64'd17);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs_n, checks_n);
    $finish;
  end

endmodule
